saus_row_collector: RTL

Collects residual samples streamed LANES per beat into one complete 32-entry row vector for the SAUS input-selection stage, which consumes a full 32-entry vector per operation. Supports transform row lengths 4/8/16/32, with valid/ready handshakes on both sides. It has a one-row skid slot so upstream streams at one beat per cycle while the output drains.

---
 rtl/saus_row_collector.sv | 132 +++++++++++++
 1 files changed

// File: rtl/saus_row_collector.sv
// Gathers LANES-wide sample beats into a full 32-entry row vector, with a one-row parked slot behind the output register.
// Build option: define SAUS_ROW_CLEAR_EN to force entries beyond the row length to zero.
module saus_row_collector #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [LANES-1:0],
    input  logic [1:0]       in_size,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vector [31:0],
    output logic [1:0]       out_size
);

    localparam int MAX_BEATS  = 32 / LANES;
    localparam int CW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int LANE_SHIFT = $clog2(LANES);

    logic [CW-1:0]    beat_cnt_reg;
    logic [1:0]       size_reg;
    logic             fill_full_reg;
    logic [WIDTH-1:0] fill_buf_reg   [31:0];
    logic [WIDTH-1:0] out_vector_reg [31:0];
    logic             out_valid_reg;
    logic [1:0]       out_size_reg;

    logic             beat_fire;
    logic             first_beat;
    logic [1:0]       row_size;
    logic [5:0]       row_len;
    logic [5:0]       row_beats_m1;
    logic             last_beat;
    logic             slot_free;
    logic             load_new;
    logic             park_row;
    logic             load_parked;
    logic [WIDTH-1:0] merged [31:0];

    assign in_ready   = !rst && !fill_full_reg;
    assign beat_fire  = in_valid && in_ready;
    assign first_beat = (beat_cnt_reg == '0);

    // The size is only trusted on the first beat; afterwards the latched copy governs the row.
    assign row_size     = first_beat ? in_size : size_reg;
    assign row_len      = 6'd4 << row_size;
    assign row_beats_m1 = (row_len >> LANE_SHIFT) - 6'd1;
    assign last_beat    = (beat_cnt_reg == row_beats_m1[CW-1:0]);

    assign slot_free   = !out_valid_reg || out_ready;
    assign load_new    = beat_fire && last_beat && slot_free;
    assign park_row    = beat_fire && last_beat && !slot_free;
    assign load_parked = fill_full_reg && slot_free;

    // Fill buffer with the current beat overlaid at its lane positions.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_merge
            localparam int BEAT_IDX = gi / LANES;
            localparam int LANE_IDX = gi % LANES;
            logic hit;
            assign hit = (beat_cnt_reg == CW'(BEAT_IDX));
`ifdef SAUS_ROW_CLEAR_EN
            assign merged[gi] = hit ? in_data[LANE_IDX]
                              : (first_beat ? '0 : fill_buf_reg[gi]);
`else
            assign merged[gi] = hit ? in_data[LANE_IDX] : fill_buf_reg[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                fill_buf_reg[i]   <= '0;
                out_vector_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (beat_fire) begin
                    fill_buf_reg[i] <= merged[i];
                end
                if (load_new) begin
                    out_vector_reg[i] <= merged[i];
                end else if (load_parked) begin
                    out_vector_reg[i] <= fill_buf_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg  <= '0;
            size_reg      <= 2'd0;
            fill_full_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_size_reg  <= 2'd0;
        end else begin
            if (beat_fire) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + CW'(1);
                if (first_beat) begin
                    size_reg <= in_size;
                end
            end

            // Parking and unparking are exclusive: in_ready is low while a row is parked.
            if (park_row) begin
                fill_full_reg <= 1'b1;
            end else if (load_parked) begin
                fill_full_reg <= 1'b0;
            end

            if (load_new) begin
                out_valid_reg <= 1'b1;
                out_size_reg  <= row_size;
            end else if (load_parked) begin
                out_valid_reg <= 1'b1;
                out_size_reg  <= size_reg;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_size   = out_size_reg;
    assign out_vector = out_vector_reg;

endmodule
